// File: rtl/dvi_timing_pkg.sv
// Shared types and default 640x480@60 timing for the DVI timing controller.
// Region decode helper is used by each axis counter.
package dvi_timing_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    RG_ACTIVE,
    RG_FP,
    RG_SYNC,
    RG_BP
  } region_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 12;

  function automatic region_e axis_region(
    input int cnt,
    input int act,
    input int fp,
    input int sync
  );
    region_e rg;
    if (cnt < act) begin
      rg = RG_ACTIVE;
    end else if (cnt < act + fp) begin
      rg = RG_FP;
    end else if (cnt < act + fp + sync) begin
      rg = RG_SYNC;
    end else begin
      rg = RG_BP;
    end
    return rg;
  endfunction

endpackage

// File: rtl/dvi_axis_counter.sv
// One timing axis: position counter with wrap and region decode
// of the value it will hold after the coming clock edge.
module dvi_axis_counter
  import dvi_timing_pkg::*;
#(
  parameter int CW     = DEF_CW,
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [CW-1:0] o_cnt,
  output logic [CW-1:0] o_cnt_next,
  output logic          o_last,
  output logic          o_next_active,
  output logic          o_next_sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  region_e       rg_next;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_adv) begin
      cnt_d = o_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_comb begin
    rg_next = axis_region(int'(cnt_d), ACTIVE, FP, SYNC);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt         = cnt_q;
  assign o_cnt_next    = cnt_d;
  assign o_last        = (cnt_q == LAST);
  assign o_next_active = (rg_next == RG_ACTIVE);
  assign o_next_sync   = (rg_next == RG_SYNC);

endmodule

// File: rtl/dvi_timing_ctrl.sv
// Display timing controller: counters, DE/sync and pixel-pair fetch
// for the six TMDS encoders; starts and stops only on frame boundaries.
module dvi_timing_ctrl
  import dvi_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   CW       = DEF_CW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  input  logic [47:0]   i_pix_data,
  input  logic          i_pix_valid,
  input  logic          i_clr_underflow,
  output logic          o_pix_req,
  output logic          o_de,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic [1:0]    o_ctrl_ch0,
  output logic [47:0]   o_data,
  output logic [CW-1:0] o_hcnt,
  output logic [CW-1:0] o_vcnt,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic          o_underflow,
  output logic          o_running
);

  state_e state_q, state_d;
  logic   run;
  logic   run_nx;

  logic          h_last, v_last;
  logic          h_nact, v_nact;
  logic          h_nsync, v_nsync;
  logic [CW-1:0] h_next, v_next;

  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;
  logic        uf_q, uf_d;
  logic [47:0] data_q, data_d;

  assign run = (state_q == ST_RUN);

  dvi_axis_counter #(
    .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP),
    .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clr        (!run),
    .i_adv        (run),
    .o_cnt        (o_hcnt),
    .o_cnt_next   (h_next),
    .o_last       (h_last),
    .o_next_active(h_nact),
    .o_next_sync  (h_nsync)
  );

  dvi_axis_counter #(
    .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP),
    .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clr        (!run),
    .i_adv        (run && h_last),
    .o_cnt        (o_vcnt),
    .o_cnt_next   (v_next),
    .o_last       (v_last),
    .o_next_active(v_nact),
    .o_next_sync  (v_nsync)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_enable) state_d = ST_RUN;
      ST_RUN: begin
        if (h_last && v_last && !i_enable) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Every registered output is derived from the position after the edge.
  always_comb begin
    run_nx = (state_d == ST_RUN);
    de_d   = run_nx && h_nact && v_nact;
    hs_d   = h_nsync ? H_POL : ~H_POL;
    vs_d   = v_nsync ? V_POL : ~V_POL;
    ls_d   = run_nx && (h_next == '0);
    fs_d   = ls_d && (v_next == '0);
    data_d = (de_d && i_pix_valid) ? i_pix_data : '0;
    uf_d   = uf_q;
    if (i_clr_underflow) uf_d = 1'b0;
    if (de_d && !i_pix_valid) uf_d = 1'b1;
  end

  assign o_pix_req = de_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      de_q    <= 1'b0;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
      data_q  <= data_d;
    end
  end

  assign o_de          = de_q;
  assign o_hsync       = hs_q;
  assign o_vsync       = vs_q;
  assign o_ctrl_ch0    = {vs_q, hs_q};
  assign o_data        = data_q;
  assign o_line_start  = ls_q;
  assign o_frame_start = fs_q;
  assign o_underflow   = uf_q;
  assign o_running     = run;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Bench for dvi_timing_ctrl on a 7x5 raster (H 4/1/1/1, V 2/1/1/1).
// Pixel data goes through a scoreboard queue popped wherever o_de is high.
module tb_dvi_timing_ctrl;

  localparam int HT = 7;
  localparam int FT = 35;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [47:0] i_pix_data = '0;
  logic        i_pix_valid = 1'b1;
  logic        i_clr_underflow = 1'b0;

  logic        o_pix_req, o_de, o_hsync, o_vsync;
  logic [1:0]  o_ctrl_ch0;
  logic [47:0] o_data;
  logic [11:0] o_hcnt, o_vcnt;
  logic        o_line_start, o_frame_start;
  logic        o_underflow, o_running;

  dvi_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CW(12)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_enable       (i_enable),
    .i_pix_data     (i_pix_data),
    .i_pix_valid    (i_pix_valid),
    .i_clr_underflow(i_clr_underflow),
    .o_pix_req      (o_pix_req),
    .o_de           (o_de),
    .o_hsync        (o_hsync),
    .o_vsync        (o_vsync),
    .o_ctrl_ch0     (o_ctrl_ch0),
    .o_data         (o_data),
    .o_hcnt         (o_hcnt),
    .o_vcnt         (o_vcnt),
    .o_line_start   (o_line_start),
    .o_frame_start  (o_frame_start),
    .o_underflow    (o_underflow),
    .o_running      (o_running)
  );

  always #5 i_clk = ~i_clk;

  int          n_pass = 0;
  int          n_tot = 0;
  int          req_cnt = 0;
  logic        mon_en = 1'b0;
  logic [47:0] exp_q[$];
  logic [47:0] src_data = 48'h060504030201;

  task automatic chk(input string nm, input logic [47:0] got,
                     input logic [47:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic bit is_act(input int p);
    return ((p % HT) < 4) && ((p / HT) < 2);
  endfunction

  // Scoreboard monitor: pop one expected word per DE cycle.
  always @(negedge i_clk) begin
    if (mon_en) begin
      chk("ctrl_ch0", 48'(o_ctrl_ch0), 48'({o_vsync, o_hsync}));
      if (o_de) begin
        if (exp_q.size() == 0) begin
          chk("data_sb_empty", 48'(exp_q.size()), 48'(1));
        end else begin
          chk("data", o_data, exp_q.pop_front());
        end
      end else begin
        chk("data_blank", o_data, 48'h0);
      end
    end
  end

  // FWFT source: head value shown, advanced only on a valid pop.
  task automatic cyc(input bit exp_req, input bit drop, input bit clr);
    i_pix_data      = src_data;
    i_clr_underflow = clr;
    i_pix_valid     = !drop;
    #1;
    chk("pix_req", 48'(o_pix_req), 48'(exp_req));
    if (o_pix_req) begin
      req_cnt++;
      exp_q.push_back(drop ? 48'h0 : src_data);
      if (!drop) src_data = src_data + 48'h010101010101;
    end
    @(posedge i_clk);
    #1;
    i_pix_valid     = 1'b1;
    i_clr_underflow = 1'b0;
  endtask

  task automatic chk_pos(input int p);
    int h;
    int v;
    h = p % HT;
    v = p / HT;
    chk("running", 48'(o_running), 48'(1));
    chk("hcnt", 48'(o_hcnt), 48'(h));
    chk("vcnt", 48'(o_vcnt), 48'(v));
    chk("de", 48'(o_de), 48'(h < 4 && v < 2));
    chk("hsync", 48'(o_hsync), 48'(h != 5));
    chk("vsync", 48'(o_vsync), 48'(v != 3));
    chk("line_start", 48'(o_line_start), 48'(h == 0));
    chk("frame_start", 48'(o_frame_start), 48'(p == 0));
  endtask

  task automatic step(input int p, input bit drop, input bit clr);
    cyc(is_act(p), drop, clr);
    chk_pos(p);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_running"}, 48'(o_running), 48'(0));
    chk({tag, "_de"}, 48'(o_de), 48'(0));
    chk({tag, "_hsync"}, 48'(o_hsync), 48'(1));
    chk({tag, "_vsync"}, 48'(o_vsync), 48'(1));
    chk({tag, "_hcnt"}, 48'(o_hcnt), 48'(0));
    chk({tag, "_vcnt"}, 48'(o_vcnt), 48'(0));
    chk({tag, "_fs"}, 48'(o_frame_start), 48'(0));
    chk({tag, "_ls"}, 48'(o_line_start), 48'(0));
    chk({tag, "_data"}, o_data, 48'h0);
    chk({tag, "_ctrl"}, 48'(o_ctrl_ch0), 48'(3));
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk_idle("rst");
    chk("rst_uf", 48'(o_underflow), 48'(0));
    chk("rst_req", 48'(o_pix_req), 48'(0));
    i_rst_n = 1'b1;
    mon_en  = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk_idle("idle");

    // Frame 1: clean run.
    i_enable = 1'b1;
    req_cnt  = 0;
    for (int p = 0; p < FT; p++) step(p, 1'b0, 1'b0);
    chk("req_per_frame1", 48'(req_cnt), 48'(8));

    // Frame 2: third request arrives without data.
    req_cnt = 0;
    for (int p = 0; p < FT; p++) begin
      step(p, p == 2, 1'b0);
      if (p == 2) chk("uf_set", 48'(o_underflow), 48'(1));
    end
    chk("req_per_frame2", 48'(req_cnt), 48'(8));
    chk("uf_held", 48'(o_underflow), 48'(1));

    // Frame 3: clear alone, then clear racing a new underflow.
    for (int p = 0; p < FT; p++) begin
      step(p, p == 1 || p == 3, p == 2 || p == 3 || p == 4);
      if (p == 2) chk("uf_clr", 48'(o_underflow), 48'(0));
      if (p == 3) chk("uf_set_wins", 48'(o_underflow), 48'(1));
      if (p == 4) chk("uf_clr2", 48'(o_underflow), 48'(0));
    end

    // Frame 4: enable dropped mid-frame, frame still completes.
    for (int p = 0; p < FT; p++) begin
      if (p == 7) i_enable = 1'b0;
      step(p, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk_idle("stop");
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk_idle("stop_hold");

    // Restart, then async reset at (2,1) while DE is high.
    i_enable = 1'b1;
    for (int p = 0; p < 10; p++) step(p, 1'b0, 1'b0);
    #1;
    i_rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_uf", 48'(o_underflow), 48'(0));
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    for (int p = 0; p < FT; p++) step(p, 1'b0, 1'b0);
    chk("sb_drained", 48'(exp_q.size()), 48'(0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
